mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for a single shared memory port in the multi-cycle CPU variant. Instruction fetch (IF stage) and data access (MEM stage) both target one unified memory. The block picks one requester at a time, holds the memory request until the memory acknowledges, and then returns read data to the winner. Data accesses have priority, and a starvation guard makes sure fetch is always served within a bounded number of data transactions.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 3, consecutive data grants allowed while a fetch is pending before fetch is forced (1..15)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  AW  fetch address, stable while if_req
- if_gnt  out  1  one-cycle pulse: fetch transaction issued
- if_rdata  out  DW  fetched word, valid when if_valid
- if_valid  out  1  one-cycle pulse: fetch complete
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = write, 0 = read; stable while dm_req
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_gnt  out  1  one-cycle pulse: data transaction issued
- dm_rdata  out  DW  read word, valid when dm_valid
- dm_valid  out  1  one-cycle pulse: data transaction complete (reads and writes)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, sampled when mem_ack
- mem_ack  in  1  memory completion, one cycle, at least 1 cycle after mem_req rises

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE, no request: stay in IDLE.
- IDLE, one requester: grant it.
- IDLE, both requesting: grant data, unless wait_cnt == MAX_WAIT, in which case grant fetch.
- Grant to X:
  - register mem_req=1.
  - register mem_addr, mem_we, mem_wdata from X. A fetch grant forces mem_we=0 and mem_wdata=0.
  - pulse X_gnt.
  - move to BUSY_X.
- BUSY_X without mem_ack: hold all mem_* outputs unchanged.
- BUSY_X with mem_ack:
  - clear mem_req and mem_we.
  - capture mem_rdata into X_rdata, including for writes.
  - pulse X_valid.
  - return to IDLE.
- wait_cnt (4 bits):
  - increments on a data grant while if_req=1, saturating at MAX_WAIT.
  - clears on a fetch grant.
  - holds otherwise.
- X_rdata holds its last captured value until the next completion for X.
- mem_ack in IDLE is ignored: no state change, no valid pulse.
- A requester that drops req mid-transaction does not abort the transaction. The memory access completes and X_valid still pulses.
- Requests seen during the cycle that X_valid is asserted are not arbitrated until the following cycle, because the FSM is in IDLE only from that cycle on.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, wait_cnt 0.
- Reset is asynchronous. Asserting it mid-transaction drops the transaction immediately: mem_req falls, and no valid pulse is produced for the dropped transaction.
- Request latency: req seen in IDLE at edge N gives mem_req=1 and X_gnt=1 after edge N.
- Completion latency: mem_ack=1 sampled at edge M gives X_valid=1 with X_rdata after edge M, with mem_req=0 in the same cycle.
- Back-to-back transactions: a second request pending at edge M+1 is granted then, so mem_req is low for exactly one cycle between transactions.
- Minimum transaction length, request to valid: 3 cycles with a 1-cycle memory.
- if_gnt and dm_gnt are never high together. if_valid and dm_valid are never high together.

## Test plan
- Single fetch: if_addr=0x0000_0040, memory acks 1 cycle after mem_req with 0x2002_0005.
  - Required: if_gnt one cycle; mem_addr=0x40, mem_we=0; if_valid one cycle with if_rdata=0x2002_0005.
  - Required: dm_* outputs stay 0.
- Simultaneous requests: if_req and dm_req in the same cycle, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF.
  - Required: data served first, with mem_we=1 and mem_wdata=0xDEAD_BEEF.
  - Required: after dm_valid, one idle cycle, then fetch granted.
- Starvation guard: MAX_WAIT=3, if_req held high, dm_req re-asserted immediately after every dm_valid.
  - Required order: exactly 3 dm_gnt, then if_gnt; wait_cnt returns to 0.
- Variable latency: mem_ack delayed 5 cycles.
  - Required: mem_req, mem_addr, mem_we and mem_wdata hold constant for all 5 cycles; valid pulses exactly once.
- Reset mid-transaction: assert rst while in BUSY_DM.
  - Required: all outputs read 0 immediately.
  - Required: after release, a later stray mem_ack produces no valid pulse.
- Spurious ack in IDLE: pulse mem_ack with no request pending.
  - Required: no valid pulse, no state change, X_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data access.
// Data wins ties; a wait counter forces a fetch after MAX_WAIT data grants.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    wait_q;
  logic [3:0]    wait_d;
  logic          pick_dm;
  logic          pick_if;

  logic          mem_req_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          if_gnt_d;
  logic          dm_gnt_d;
  logic          if_valid_d;
  logic          dm_valid_d;
  logic [DW-1:0] if_rdata_d;
  logic [DW-1:0] dm_rdata_d;

  // Fetch only overrides data once the wait budget is used up.
  assign pick_dm = dm_req && !(if_req && (wait_q == WAIT_MAX));
  assign pick_if = if_req && !pick_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_dm: begin
            state_d     = BUSY_DM;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            dm_gnt_d    = 1'b1;
            if (if_req && (wait_q != WAIT_MAX))
              wait_d = wait_q + 4'd1;
          end
          pick_if: begin
            state_d     = BUSY_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            if_gnt_d    = 1'b1;
            wait_d      = '0;
          end
          default: ;
        endcase
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dm_rdata_d = mem_rdata;
          dm_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rdata(dm_rdata),
    .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, and how many data grants
  // have passed a waiting fetch.
  int            owner;
  int            streak;
  logic          e_req, e_we, e_ig, e_dg, e_iv, e_dv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_ir, e_dr;

  task automatic model_reset();
    owner = 0; streak = 0;
    e_req = 0; e_we = 0; e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0;
    e_addr = '0; e_wd = '0; e_ir = '0; e_dr = '0;
  endtask

  task automatic model_edge();
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0;
    if (owner == 0) begin
      if (dm_req && !(if_req && streak == MW)) begin
        owner = 2; e_req = 1; e_we = dm_we;
        e_addr = dm_addr; e_wd = dm_wdata; e_dg = 1;
        if (if_req) streak = (streak + 1 > MW) ? MW : streak + 1;
      end else if (if_req) begin
        owner = 1; e_req = 1; e_we = 0;
        e_addr = if_addr; e_wd = '0; e_ig = 1;
        streak = 0;
      end
    end else if (mem_ack) begin
      e_req = 0; e_we = 0;
      if (owner == 1) begin e_ir = mem_rdata; e_iv = 1; end
      else begin e_dr = mem_rdata; e_dv = 1; end
      owner = 0;
    end
  endtask

  task automatic compare_all();
    check("mem_req", 64'(mem_req), 64'(e_req));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    check("if_gnt", 64'(if_gnt), 64'(e_ig));
    check("dm_gnt", 64'(dm_gnt), 64'(e_dg));
    check("if_valid", 64'(if_valid), 64'(e_iv));
    check("dm_valid", 64'(dm_valid), 64'(e_dv));
    check("if_rdata", 64'(if_rdata), 64'(e_ir));
    check("dm_rdata", 64'(dm_rdata), 64'(e_dr));
  endtask

  // Stimulus agents
  int            lat = -1;
  int            fixed_lat = 0;
  bit            spur_en = 0;
  bit            auto_req = 0;
  bit            keep_if = 0;
  bit            keep_dm = 0;
  bit            rd_fixed = 0;
  logic [DW-1:0] rd_val = '0;

  task automatic drive();
    if (mem_req) begin
      if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 5);
      if (lat == 0) begin
        mem_ack = 1;
        mem_rdata = rd_fixed ? rd_val : $urandom;
        lat = -1;
      end else begin
        mem_ack = 0;
        lat--;
      end
    end else begin
      lat = -1;
      mem_ack = spur_en && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
    if (if_valid && !keep_if) if_req = 0;
    if (dm_valid && !keep_dm) dm_req = 0;
    if (auto_req) begin
      if (if_gnt && $urandom_range(0, 9) == 0) if_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!dm_req && $urandom_range(0, 3) != 0) begin
        dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom;
        dm_wdata = $urandom;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    else model_reset();
    #1;
    compare_all();
    drive();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic mid_reset();
    #3;
    rst = 0;
    #1;
    model_reset();
    compare_all();
    lat = -1;
    mem_ack = 0;
    step();
    step();
    rst = 1;
  endtask

  int nd, cyc, t_dv, t_ig, reqc, vc;
  bit seen, first_dm, got_first;
  logic [DW-1:0] saved;

  initial begin
    model_reset();
    #1;
    compare_all();
    step();
    step();
    rst = 1;

    // single fetch
    fixed_lat = 0; rd_fixed = 1; rd_val = 32'h2002_0005;
    if_req = 1; if_addr = 32'h0000_0040;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (if_gnt) begin
        check("fetch_addr", 64'(mem_addr), 64'h40);
        check("fetch_we", 64'(mem_we), 64'h0);
      end
      if (if_valid) begin
        seen = 1;
        check("fetch_rdata", 64'(if_rdata), 64'h2002_0005);
      end
    end
    check("fetch_done", 64'(seen), 64'h1);
    step();

    // simultaneous requests: data first, fetch right after
    rd_fixed = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h200;
    seen = 0; got_first = 0; first_dm = 0; t_dv = -100; t_ig = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (!got_first && (dm_gnt || if_gnt)) begin
        got_first = 1; first_dm = dm_gnt;
        check("sim_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("sim_we", 64'(mem_we), 64'h1);
      end
      if (dm_valid) t_dv = i;
      if (if_gnt) t_ig = i;
      if (if_valid) seen = 1;
    end
    check("sim_data_first", 64'(first_dm), 64'h1);
    check("sim_gap", 64'(t_ig - t_dv), 64'h1);
    step();

    // spurious ack while idle
    saved = if_rdata;
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    check("spur_if_valid", 64'(if_valid), 64'h0);
    check("spur_dm_valid", 64'(dm_valid), 64'h0);
    check("spur_rdata", 64'(if_rdata), 64'(saved));
    step();

    // variable latency: five wait cycles before ack
    fixed_lat = 5;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    reqc = 0; vc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req) reqc++;
      if (dm_valid) vc++;
    end
    check("lat_req_cycles", 64'(reqc), 64'd6);
    check("lat_valids", 64'(vc), 64'd1);

    // reset while a data access is outstanding
    dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'h55;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dm_gnt) seen = 1;
    end
    step();
    dm_req = 0;
    mid_reset();
    step();
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    vc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dm_valid || if_valid) vc++;
    end
    check("stray_ack_valid", 64'(vc), 64'd0);

    // starvation guard
    fixed_lat = 0; keep_if = 1; keep_dm = 1;
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h500;
    nd = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (dm_gnt) nd++;
      if (if_gnt) seen = 1;
    end
    check("starve_if_gnt", 64'(seen), 64'h1);
    check("starve_dm_gnts", 64'(nd), 64'(MW));
    check("starve_wait_clr", 64'(dut.wait_q), 64'h0);
    keep_if = 0; keep_dm = 0;
    for (int i = 0; i < 10; i++) step();

    // random traffic
    fixed_lat = -1; spur_en = 1; auto_req = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      check("gnt_excl", 64'(if_gnt & dm_gnt), 64'h0);
      check("valid_excl", 64'(if_valid & dm_valid), 64'h0);
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
